// File: rtl/aes_pkg.sv
// aes_pkg: key-length encodings, schedule-size lookups, rcon helpers and FSM states for the AES key expander
package aes_pkg;
  localparam logic [1:0] AES_KEY_128 = 2'd0;
  localparam logic [1:0] AES_KEY_192 = 2'd1;
  localparam logic [1:0] AES_KEY_256 = 2'd2;
  localparam logic [7:0] RCON_INIT = 8'h01;
  typedef enum logic [1:0] {IDLE, LOAD, GEN, DONE} state_t;
  function automatic logic [3:0] nk_of(input logic [1:0] l);
    return l == AES_KEY_256 ? 4'd8 : l == AES_KEY_192 ? 4'd6 : 4'd4;
  endfunction
  function automatic logic [3:0] nr_of(input logic [1:0] l);
    return l == AES_KEY_256 ? 4'd14 : l == AES_KEY_192 ? 4'd12 : 4'd10;
  endfunction
  function automatic logic [5:0] t_of(input logic [1:0] l);
    return l == AES_KEY_256 ? 6'd60 : l == AES_KEY_192 ? 6'd52 : 6'd44;
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (8'h1b & {8{r[7]}});
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: AES forward S-box computed as GF(2^8) inverse (x^254) followed by the affine map
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p = '0;
    xx = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ xx;
      xx = xtime(xx);
    end
    return p;
  endfunction
  logic [7:0] sq, inv;
  always_comb begin
    sq = din;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

// File: rtl/aes_key_expander_mslot.sv
// aes_key_expander_mslot: word-serial AES-128/192/256 key expander with KEY_SLOTS stored schedules and a registered round-key read port
module aes_key_expander_mslot
  import aes_pkg::*;
#(
  parameter int KEY_SLOTS = 2,
  parameter int SLOT_W = (KEY_SLOTS > 1) ? $clog2(KEY_SLOTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [255:0]         cipher_key,
  input  logic [1:0]           key_len,
  input  logic [SLOT_W-1:0]    load_slot,
  input  logic                 k_valid,
  output logic                 k_ready,
  output logic                 k_err,
  output logic                 busy,
  output logic                 done,
  output logic [KEY_SLOTS-1:0] slot_valid,
  input  logic                 rd_en,
  input  logic [SLOT_W-1:0]    rd_slot,
  input  logic [3:0]           rd_round,
  output logic                 rd_valid,
  output logic [127:0]         rd_key
);
  state_t state_q, state_d;
  logic [SLOT_W-1:0] slot_q;
  logic [1:0] len_q;
  logic [5:0] i_q;
  logic [2:0] kc_q;
  logic [7:0] rcon_q;
  logic [31:0] win_q [8];
  logic [31:0] bank_q [4][KEY_SLOTS][15];
  logic [1:0] slot_len [KEY_SLOTS];
  logic [3:0] nk;
  logic [5:0] tw;
  logic legal, acc, wr_en, kc_wrap, rd_ok;
  logic [31:0] t, sw_in, sw, temp, w_new, wr_data;
  logic [127:0] rd_data;
  assign nk = nk_of(len_q);
  assign tw = t_of(len_q);
  assign legal = key_len != 2'd3 && int'(load_slot) < KEY_SLOTS;
  assign acc = k_valid && state_q == IDLE && legal;
  assign wr_en = state_q == LOAD || (state_q == GEN && i_q != tw);
  assign kc_wrap = {1'b0, kc_q} == nk - 4'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q == IDLE ? (acc ? LOAD : IDLE) :
              state_q == LOAD ? (kc_wrap ? GEN : LOAD) :
              state_q == GEN  ? (i_q == tw ? DONE : GEN) : IDLE;
  end
  always_comb begin
    k_ready = state_q == IDLE;
    busy = state_q != IDLE;
    done = state_q == DONE;
  end
  // Window keeps the newest word at index 7, so w[i-Nk] sits at 8-Nk
  always_comb begin
    t = win_q[7];
    sw_in = kc_q == 3'd0 ? {t[23:0], t[31:24]} : t;
    temp = kc_q == 3'd0 ? sw ^ {rcon_q, 24'h0} : (nk == 4'd8 && kc_q == 3'd4) ? sw : t;
    w_new = win_q[3'(4'd8 - nk)] ^ temp;
    wr_data = state_q == LOAD ? win_q[0] : w_new;
  end
  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (.din(sw_in[8*b +: 8]), .dout(sw[8*b +: 8]));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot_q <= '0;
      len_q <= '0;
      i_q <= '0;
      kc_q <= '0;
      rcon_q <= RCON_INIT;
      k_err <= 1'b0;
      slot_valid <= '0;
      rd_valid <= 1'b0;
      rd_key <= '0;
    end else begin
      k_err <= k_valid && state_q == IDLE && !legal;
      rd_valid <= rd_en;
      rd_key <= rd_ok ? rd_data : '0;
      if (acc) begin
        slot_q <= load_slot;
        len_q <= key_len;
        i_q <= '0;
        kc_q <= '0;
        rcon_q <= RCON_INIT;
        slot_valid[load_slot] <= 1'b0;
      end else if (wr_en) begin
        i_q <= i_q + 6'd1;
        kc_q <= kc_wrap ? 3'd0 : kc_q + 3'd1;
        if (state_q == GEN && kc_q == 3'd0) rcon_q <= xtime(rcon_q);
      end
      if (state_q == GEN && i_q == tw) slot_valid[slot_q] <= 1'b1;
    end
  // LOAD rotates the key words out of the window; GEN shifts new words in
  always_ff @(posedge clk)
    if (acc) begin
      for (int j = 0; j < 8; j++) win_q[j] <= cipher_key[255-32*j -: 32];
      slot_len[load_slot] <= key_len;
    end else if (wr_en) begin
      for (int j = 0; j < 7; j++) win_q[j] <= win_q[j+1];
      win_q[7] <= wr_data;
      bank_q[i_q[1:0]][slot_q][i_q[5:2]] <= wr_data;
    end
  always_comb begin
    rd_ok = rd_en && int'(rd_slot) < KEY_SLOTS && slot_valid[rd_slot] &&
            rd_round <= nr_of(slot_len[rd_slot]) && !(state_q != IDLE && rd_slot == slot_q);
    rd_data = '0;
    for (int b = 0; b < 4; b++) rd_data[127-32*b -: 32] = bank_q[b][rd_slot][rd_round];
  end
endmodule
